// File: rtl/ecc_pkg.sv
// ecc_pkg: SECDED code constants, decode/FSM types and data-bit placement
package ecc_pkg;
    localparam int CW_W = 72;
    localparam int DATA_W = 64;
    localparam int CHK_W = 8;
    typedef enum logic [1:0] {CLEAN, CE, UE} dec_status_t;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ} state_t;
    function automatic logic [6:0] data_pos(input int i);
        int n;
        data_pos = '0;
        n = 0;
        for (int p = 3; p < CW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == i) data_pos = 7'(p);
                n++;
            end
        end
    endfunction
endpackage

// File: rtl/secded_decode.sv
// secded_decode: combinational extended-Hamming check and single-bit correction
module secded_decode
    import ecc_pkg::*;
(
    input  logic [CW_W-1:0] cw,
    output dec_status_t     status,
    output logic [6:0]      syndrome,
    output logic [CW_W-1:0] corrected
);
    logic [6:0] calc;
    logic [CW_W-1:0] flip;
    logic par;
    always_comb begin
        calc = '0;
        for (int i = 0; i < DATA_W; i++) calc = calc ^ (cw[i] ? data_pos(i) : 7'd0);
    end
    assign syndrome = calc ^ cw[DATA_W +: 7];
    assign par = ^cw;
    always_comb begin
        flip = '0;
        if (par) begin
            flip[CW_W-1] = (syndrome == 7'd0);
            for (int j = 0; j < 7; j++) flip[DATA_W+j] = (syndrome == 7'(1 << j));
            for (int i = 0; i < DATA_W; i++) flip[i] = (syndrome == data_pos(i));
        end
    end
    assign corrected = cw ^ flip;
    assign status = !par ? ((syndrome == 7'd0) ? CLEAN : UE) : ((syndrome > 7'd71) ? UE : CE);
endmodule

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: walks the array, writes back single-bit corrections, reports uncorrectable words
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int ADDR_W = 10,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CW_W-1:0]   mem_wdata,
    input  logic [CW_W-1:0]   mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              ue_valid,
    output logic [ADDR_W-1:0] ue_addr,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count
);
    state_t state;
    logic [CW_W-1:0] rdata_q;
    logic [CW_W-1:0] corrected;
    dec_status_t status;
    logic [6:0] unused_syndrome;
    logic advance;
    secded_decode u_dec (
        .cw(rdata_q),
        .status(status),
        .syndrome(unused_syndrome),
        .corrected(corrected)
    );
    assign advance = (state == CHECK && status != CE) || (state == WR_REQ && mem_gnt);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            rdata_q <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            ue_valid <= 1'b0;
            ue_addr <= '0;
            ce_count <= '0;
            ue_count <= '0;
        end else begin
            done <= 1'b0;
            ue_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= RD_REQ;
                    mem_addr <= '0;
                    ce_count <= '0;
                    ue_count <= '0;
                    busy <= 1'b1;
                    mem_req <= 1'b1;
                    mem_we <= 1'b0;
                end
                RD_REQ: if (mem_gnt) begin
                    state <= RD_WAIT;
                    mem_req <= 1'b0;
                end
                RD_WAIT: begin
                    rdata_q <= mem_rdata;
                    state <= CHECK;
                end
                CHECK: begin
                    if (status == CE) begin
                        if (!(&ce_count)) ce_count <= ce_count + 1'b1;
                        mem_wdata <= corrected;
                        mem_we <= 1'b1;
                        mem_req <= 1'b1;
                        state <= WR_REQ;
                    end else if (status == UE) begin
                        if (!(&ue_count)) ue_count <= ue_count + 1'b1;
                        ue_valid <= 1'b1;
                        ue_addr <= mem_addr;
                    end
                end
                default: ;
            endcase
            // clean/UE words leave CHECK here; CE words leave WR_REQ here on grant
            if (advance) begin
                mem_we <= 1'b0;
                if (mem_addr == ADDR_W'(DEPTH - 1)) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    mem_req <= 1'b0;
                end else begin
                    mem_addr <= mem_addr + 1'b1;
                    state <= RD_REQ;
                    mem_req <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ecc_scrubber.sv
// tb_ecc_scrubber: array model with grant stalls, write/UE scoreboards and pass-level checks
module tb_ecc_scrubber;
    typedef struct {
        logic [3:0]  a;
        logic [71:0] d;
    } wr_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic mem_req;
    logic mem_gnt = 1'b1;
    logic mem_we;
    logic [3:0] mem_addr;
    logic [71:0] mem_wdata;
    logic [71:0] mem_rdata = '0;
    logic busy, done, ue_valid;
    logic [3:0] ue_addr;
    logic [15:0] ce_count, ue_count;
    logic [71:0] mem [16];
    wr_t wq[$];
    logic [3:0] ueq[$];
    int total = 0;
    int bad = 0;
    int reads = 0;
    int writes = 0;
    int ue_pulses = 0;
    int first_rd = -1;
    int stall_rd = -1;
    bit stall_wr = 1'b0;
    int stall_left = 0;
    bit had_stall = 1'b0;
    logic [77:0] snap = '0;
    bit rd_pend = 1'b0;
    logic [3:0] rd_a = '0;
    bit prev_busy = 1'b0;
    ecc_scrubber #(.DEPTH(16), .ADDR_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .ue_valid(ue_valid), .ue_addr(ue_addr),
        .ce_count(ce_count), .ue_count(ue_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [71:0] enc(input logic [63:0] d);
        logic [71:0] cw;
        int n;
        cw = '0;
        cw[63:0] = d;
        n = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[n]) for (int j = 0; j < 7; j++) if (p[j]) cw[64+j] = ~cw[64+j];
                n++;
            end
        end
        cw[71] = ^cw[70:0];
        return cw;
    endfunction
    initial forever begin
        @(negedge clk);
        if (had_stall) chk("hold", {mem_req, mem_we, mem_addr, mem_wdata}, snap);
        if (stall_left > 0) begin
            stall_left--;
            mem_gnt = (stall_left == 0);
        end else if (mem_req && ((!mem_we && 32'(mem_addr) == stall_rd) || (mem_we && stall_wr))) begin
            stall_left = 5;
            mem_gnt = 1'b0;
            if (mem_we) stall_wr = 1'b0;
            else stall_rd = -1;
        end
        had_stall = mem_req && !mem_gnt && !rst;
        snap = {mem_req, mem_we, mem_addr, mem_wdata};
        mem_rdata = rd_pend ? mem[rd_a] : 'x;
        rd_pend = 1'b0;
        if (busy && !prev_busy) first_rd = -1;
        prev_busy = busy;
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                writes++;
                chk("wr_pending", 80'(wq.size() != 0), 80'd1);
                if (wq.size() != 0) begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                end
                mem[mem_addr] = mem_wdata;
            end else begin
                reads++;
                if (first_rd < 0) first_rd = 32'(mem_addr);
                rd_pend = 1'b1;
                rd_a = mem_addr;
            end
        end
        if (ue_valid) begin
            ue_pulses++;
            chk("ue_pending", 80'(ueq.size() != 0), 80'd1);
            if (ueq.size() != 0) chk("ue_addr", ue_addr, ueq.pop_front());
        end
    end
    task automatic run_pass(output int cyc, output int dr, output int dw, output int du);
        int r0, w0, u0;
        r0 = reads;
        w0 = writes;
        u0 = ue_pulses;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("cnt_clear", {ce_count, ue_count}, 0);
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
        chk("busy_fall", busy, 0);
        chk("first_rd_addr", first_rd, 0);
        dr = reads - r0;
        dw = writes - w0;
        du = ue_pulses - u0;
        chk("reads", dr, 16);
        chk("wr_q_empty", wq.size(), 0);
        chk("ue_q_empty", ueq.size(), 0);
    endtask
    initial begin
        int cyc, dr, dw, du, k;
        logic [71:0] bad7;
        for (int a = 0; a < 16; a++) mem[a] = enc(64'(a));
        repeat (3) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {done, ue_valid, mem_we}, 0);
        chk("rst_counts", {ce_count, ue_count, ue_addr}, 0);
        rst = 1'b0;
        @(negedge clk);
        run_pass(cyc, dr, dw, du);
        chk("clean_latency", cyc, 48);
        chk("clean_writes", dw, 0);
        chk("clean_counts", {ce_count, ue_count}, 0);
        mem[3] = enc(64'd3) ^ (72'd1 << 5);
        wq.push_back('{4'd3, enc(64'd3)});
        @(negedge clk);
        run_pass(cyc, dr, dw, du);
        chk("ce1_writes", dw, 1);
        chk("ce1_ce", ce_count, 1);
        chk("ce1_ue", ue_count, 0);
        chk("ce1_mem", mem[3], enc(64'd3));
        mem[0] = enc(64'd0) ^ (72'd1 << 71);
        mem[9] = enc(64'd9) ^ (72'd1 << 67);
        wq.push_back('{4'd0, enc(64'd0)});
        wq.push_back('{4'd9, enc(64'd9)});
        @(negedge clk);
        run_pass(cyc, dr, dw, du);
        chk("ce2_writes", dw, 2);
        chk("ce2_ce", ce_count, 2);
        chk("ce2_mem0", mem[0], enc(64'd0));
        chk("ce2_mem9", mem[9], enc(64'd9));
        bad7 = enc(64'd7) ^ 72'd3;
        mem[7] = bad7;
        ueq.push_back(4'd7);
        @(negedge clk);
        run_pass(cyc, dr, dw, du);
        chk("ue_pulses", du, 1);
        chk("ue_writes", dw, 0);
        chk("ue_count", ue_count, 1);
        chk("ue_ce", ce_count, 0);
        chk("ue_addr_hold", ue_addr, 7);
        chk("ue_mem", mem[7], bad7);
        mem[7] = enc(64'd7);
        mem[10] = enc(64'd10) ^ (72'd1 << 40);
        wq.push_back('{4'd10, enc(64'd10)});
        stall_rd = 4;
        stall_wr = 1'b1;
        @(negedge clk);
        run_pass(cyc, dr, dw, du);
        chk("stall_writes", dw, 1);
        chk("stall_ce", ce_count, 1);
        chk("stall_mem", mem[10], enc(64'd10));
        chk("stall_used", {stall_rd, 31'd0, stall_wr}, {-32'sd1, 32'd0});
        mem[3] = enc(64'd3) ^ (72'd1 << 20);
        stall_wr = 1'b1;
        @(negedge clk);
        dw = writes;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(mem_req && mem_we) && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("wr_req_reached", mem_req && mem_we, 1);
        chk("wr_req_addr", mem_addr, 3);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req", mem_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pulses", {done, ue_valid}, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_wr", writes - dw, 0);
        wq.push_back('{4'd3, enc(64'd3)});
        run_pass(cyc, dr, dw, du);
        chk("rescan_writes", dw, 1);
        chk("rescan_ce", ce_count, 1);
        chk("rescan_mem", mem[3], enc(64'd3));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/ecc_scrubber.md
# ecc_scrubber

Background SECDED scrubber for cache data arrays protected by the 72-bit (64 data + 8 check) extended-Hamming code. It is the decode/correct end of the fault-injection path: it walks every array entry, checks each codeword, writes back corrected codewords on single-bit errors, and reports double-bit or unrecoverable errors. It sits beside the cache array behind the array arbiter and shares the array's single read/write port through a request/grant handshake.

## Interface
- `DEPTH`, 1024: number of array entries scrubbed per pass.
- `ADDR_W`, 10: address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `CNT_W`, 16: width of the error counters.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a pass; sampled only in IDLE.
- `mem_req` out 1: array access request.
- `mem_gnt` in 1: arbiter grant; an access completes in a cycle where `mem_req & mem_gnt`.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: access address.
- `mem_wdata` out 72: write codeword.
- `mem_rdata` in 72: read codeword, valid exactly 1 cycle after the read's grant cycle.
- `busy` out 1: pass in progress.
- `done` out 1: 1-cycle pulse at the end of a pass.
- `ue_valid` out 1: 1-cycle pulse on an uncorrectable word.
- `ue_addr` out ADDR_W: address of the last uncorrectable word.
- `ce_count` out CNT_W: corrected words in the current pass; saturates.
- `ue_count` out CNT_W: uncorrectable words in the current pass; saturates.

## Operation
- Codeword layout: [63:0] data, [70:64] Hamming check c0..c6, [71] overall parity.
  - Data bit i sits at the i-th non-power-of-two Hamming position in 3..71, in ascending order.
  - cj = XOR of data bits whose position has bit j set.
  - [71] = XOR of bits [70:0].
- Decode:
  - s = recomputed c ^ stored c (7 bits); p = XOR of all 72 bits.
  - s=0, p=0: clean.
  - p=1, s=0: bit 71 is in error. This is a CE.
  - p=1, s=2^j: check bit cj is in error. This is a CE.
  - p=1, s another value ≤71: the data bit at position s is in error. This is a CE.
  - p=1, s>71: UE.
  - p=0, s≠0: UE (double error).
- Correction flips exactly the erroneous bit. The written codeword equals the original encoded word.
- State machine:
  - IDLE → RD_REQ when `start`. On entry, the address is set to 0 and both counters are cleared.
  - RD_REQ: drives `mem_req=1`, `mem_we=0`, `mem_addr=addr`. Moves to RD_WAIT on grant.
  - RD_WAIT: captures `mem_rdata` into a register, then moves to CHECK.
  - CHECK: decodes the registered word.
    - Clean: go to the next address.
    - CE: increment `ce_count`, then go to WR_REQ.
    - UE: increment `ue_count`, pulse `ue_valid`, load `ue_addr`, then go to the next address. No write is issued.
  - WR_REQ: drives `mem_req=1`, `mem_we=1`, and the same `mem_addr` with the corrected `mem_wdata`. Goes to the next address on grant.
  - Next address: if addr = DEPTH-1, go to IDLE and pulse `done`. Otherwise addr+1 and go to RD_REQ.
- `start` is ignored outside IDLE.
- Counters stop at 2^CNT_W−1 and never wrap.
- `mem_addr`, `mem_we` and `mem_wdata` hold stable while `mem_req` is high and `mem_gnt` is low.

## Timing
- Reset values:
  - All outputs 0 and state IDLE.
  - `rst` asserted mid-pass aborts the pass: `mem_req`, `busy`, `done` and `ue_valid` are 0 from the following edge, and no write is issued afterwards.
- All outputs are registered.
- With `mem_gnt` tied high:
  - Clean or UE word: 3 cycles (RD_REQ, RD_WAIT, CHECK).
  - CE word: 4 cycles.
- `busy` rises the cycle after `start` is sampled. It falls in the same cycle `done` pulses.
- `ue_valid` pulses the cycle after the CHECK cycle. `ue_addr` is updated in that same cycle and holds until the next UE.
- A full clean pass with `mem_gnt` high takes 3·DEPTH cycles from `busy` rising to `done`.

## Structure
- `ecc_pkg`:
  - Constants: CW_W=72, DATA_W=64, CHK_W=8.
  - Data-bit→Hamming-position mapping function.
  - Decode status enum {CLEAN, CE, UE}.
  - State enum.
- Sub-module `secded_decode`: combinational. Input: 72-bit codeword. Outputs: status, syndrome, corrected codeword.
- `ecc_scrubber` holds the FSM, address counter, read register and counters.

## Test plan
- Clean pass, DEPTH=16, gnt=1, array encoded from data = addr: `done` 48 cycles after `busy` rises; no writes; both counts 0.
- Flip data bit 5 at addr 3: exactly one write, to addr 3, carrying the original codeword; `ce_count`=1, `ue_count`=0.
- Flip only bit 71 at addr 0, and only c3 at addr 9: both written back corrected; `ce_count`=2.
- Flip data bits 0 and 1 at addr 7: `ue_valid` pulses once; `ue_addr`=7; no write to 7; `ue_count`=1; the array is unchanged.
- Hold `mem_gnt` low for 5 cycles during RD_REQ at addr 4, and for 5 cycles during a WR_REQ: `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` stay stable; no extra accesses occur.
- Assert `rst` for 1 cycle during WR_REQ at addr 3: next cycle `mem_req`=0 and `busy`=0. A new `start` rescans from addr 0 with counts restarted at 0.
